rr_onehot_arbiter: RTL and testbench



---
 rtl/rr_arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 40 ++++
 rtl/rr_onehot_arbiter.sv | 125 ++++++++++++
 tb/tb_rr_onehot_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// ============================================================================
// rr_arb_pkg : shared types and helpers for the round-robin one-hot arbiter
// Revision   : 1.0
// ============================================================================
`default_nettype none

package rr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    localparam int unsigned MAX_REQ = 16;

    // Index width for a requester count; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_REQ-1:0] to_onehot(input logic [3:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick  : combinational round-robin picker, first set req bit from ptr up
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    // Scan offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        int             sum;
        logic [IDX_W-1:0] cand;
        valid  = 1'b0;
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = int'(ptr) + i;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            cand = IDX_W'(sum);
            if (req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_onehot_arbiter.sv
// ============================================================================
// rr_onehot_arbiter : registered one-hot round-robin arbiter, break-before-make
// Optional checks   : RR_ONEHOT_ARBITER_CHECK_EN        Revision : 1.0
// ============================================================================
`default_nettype none

module rr_onehot_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req,
    input  logic                         done,
    output logic [N_REQ-1:0]             gnt,
    output logic [idx_width(N_REQ)-1:0]  gnt_id,
    output logic                         busy,
    output logic                         timeout
);

    localparam int IDX_W = idx_width(N_REQ);

    arb_state_e       state, state_nx;
    logic [7:0]       cnt, cnt_nx;
    logic [IDX_W-1:0] ptr, ptr_nx, id_nx, pick_idx;
    logic [N_REQ-1:0] gnt_nx;
    logic             busy_nx, to_nx, pick_valid;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ptr     <= ptr_nx;
            gnt     <= gnt_nx;
            gnt_id  <= id_nx;
            busy    <= busy_nx;
            timeout <= to_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        gnt_nx   = gnt;
        id_nx    = gnt_id;
        busy_nx  = busy;
        to_nx    = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (pick_valid) begin
                    state_nx = GRANT;
                    gnt_nx   = N_REQ'(to_onehot(4'(pick_idx)));
                    id_nx    = pick_idx;
                    busy_nx  = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                    busy_nx  = 1'b0;
                end
            end
            GRANT: begin
                // done/withdraw outrank expiry, so timeout only fires on a pure expiry.
                if (done || !req[gnt_id] || (cnt == 8'(MAX_HOLD - 1))) begin
                    state_nx = GAP;
                    gnt_nx   = '0;
                    busy_nx  = 1'b0;
                    cnt_nx   = '0;
                    ptr_nx   = (gnt_id == IDX_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
                    to_nx    = !done && req[gnt_id];
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                busy_nx  = 1'b0;
                cnt_nx   = '0;
            end
        endcase
    end

`ifdef RR_ONEHOT_ARBITER_CHECK_EN
    logic [N_REQ-1:0] id_oh;
    assign id_oh = N_REQ'(to_onehot(4'(gnt_id)));

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
        $info("onehot ok"); else $error("gnt not onehot0");
    a_busy: assert property (@(posedge clk) disable iff (!rst_n) busy == (|gnt))
        $info("busy ok"); else $error("busy disagrees with gnt");
    a_id: assert property (@(posedge clk) disable iff (!rst_n) busy |-> (gnt == id_oh))
        $info("gnt_id ok"); else $error("gnt_id disagrees with gnt");
    a_bbm: assert property (@(posedge clk) disable iff (!rst_n)
            (($past(gnt) != '0) && (gnt != '0)) |-> (gnt == $past(gnt)))
        $info("gap ok"); else $error("owner changed without gap");
    a_to: assert property (@(posedge clk) disable iff (!rst_n)
            timeout |-> ((gnt == '0) && ($past(gnt) != '0)))
        $info("timeout ok"); else $error("timeout without falling gnt");
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_onehot_arbiter.sv
// ============================================================================
// tb_rr_onehot_arbiter : directed + random bench against a behavioural model
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_rr_onehot_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic         done = 1'b0;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         timeout;

    int n_vec = 0;
    int n_err = 0;

    // Model state: current owner (-1 = nobody), cycles held, pointer, pulse.
    int m_owner = -1;
    int m_id    = 0;
    int m_hold  = 0;
    int m_ptr   = 0;
    int m_to    = 0;

    rr_onehot_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change just after posedge, so at negedge they equal what the next edge samples.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_owner = -1; m_id = 0; m_hold = 0; m_ptr = 0; m_to = 0;
            end
            check("model_gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("model_busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
            check("model_gnt_id", 32'(gnt_id), 32'(m_id));
            check("model_timeout", 32'(timeout), 32'(m_to));
            if (rst_n) begin
                m_to = 0;
                if (m_owner >= 0) begin
                    m_hold++;
                    if (done || !req[m_owner] || m_hold == MH) begin
                        m_to    = (!done && req[m_owner]) ? 1 : 0;
                        m_ptr   = (m_owner + 1) % N;
                        m_owner = -1;
                    end
                end else begin
                    for (int k = N - 1; k >= 0; k--) begin
                        if (req[(m_ptr + k) % N]) begin
                            m_owner = (m_ptr + k) % N;
                        end
                    end
                    if (m_owner >= 0) begin
                        m_id   = m_owner;
                        m_hold = 0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           held;
        int           owners[$];
        int           exp_own[5];
        logic [N-1:0] prev;

        exp_own = '{0, 1, 2, 3, 0};

        // Reset state
        repeat (3) tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request with done on the third grant cycle
        req = 4'b0010;
        tick();
        check("single_gnt1", 32'(gnt), 32'h2);
        check("single_id", 32'(gnt_id), 32'd1);
        check("single_busy", 32'(busy), 32'd1);
        tick();
        check("single_gnt2", 32'(gnt), 32'h2);
        tick();
        check("single_gnt3", 32'(gnt), 32'h2);
        done = 1'b1;
        req  = 4'b0000;
        tick();
        done = 1'b0;
        check("single_rel_gnt", 32'(gnt), 32'd0);
        check("single_rel_busy", 32'(busy), 32'd0);
        check("single_rel_id", 32'(gnt_id), 32'd1);
        check("single_rel_to", 32'(timeout), 32'd0);
        tick();

        // Timeout: requester 2 holds, nobody signals done
        req = 4'b0100;
        tick();
        check("to_gnt", 32'(gnt), 32'h4);
        held = 1;
        while (gnt != '0 && held < 20) begin
            tick();
            if (gnt != '0) held++;
        end
        check("to_hold_len", 32'(held), 32'd8);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_gap_gnt", 32'(gnt), 32'd0);
        tick();
        check("to_regrant", 32'(gnt), 32'h4);
        check("to_cleared", 32'(timeout), 32'd0);

        // done coinciding with expiry: normal release
        repeat (7) tick();
        check("exp_hold8", 32'(gnt), 32'h4);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0000;
        check("exp_rel_gnt", 32'(gnt), 32'd0);
        check("exp_rel_to", 32'(timeout), 32'd0);
        tick();

        // Withdraw: owner 0 drops request, pointer moves to 1
        req = 4'b0001;
        tick();
        check("wd_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        check("wd_rel", 32'(gnt), 32'd0);
        req = 4'b0011;
        tick();
        check("wd_next", 32'(gnt), 32'h2);
        tick();

        // Asynchronous reset mid-grant
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_id", 32'(gnt_id), 32'd0);
        repeat (2) tick();
        #2;
        rst_n = 1'b1;
        req   = 4'b1111;

        // Fairness with done every third cycle
        prev = '0;
        for (int k = 0; k < 30; k++) begin
            done = (k % 3 == 2);
            tick();
            if (gnt != '0 && prev == '0) owners.push_back(int'(gnt_id));
            prev = gnt;
        end
        done = 1'b0;
        check("fair_count", 32'(owners.size() >= 5), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < owners.size()) check("fair_owner", 32'(owners[k]), 32'(exp_own[k]));
        end

        // Random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 5) == 0);
            tick();
        end
        req  = '0;
        done = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
